frame_buf: RTL

Double-buffered RGB444 framebuffer feeding `dspl_ctrl`. The render/simulation logic writes pixels into the back buffer by (x, y). `dspl_ctrl` reads the front buffer through its `r_addr` / `din_top` / `din_btm` interface. Back and front swap only at a display frame boundary, so the panel never shows a partly drawn frame. A hardware clear fills the back buffer with a constant colour.

---
 rtl/lava_pkg.sv | 17 +
 rtl/fb_ram.sv | 32 +++
 rtl/frame_buf.sv | 137 +++++++++++++
 3 files changed

// File: rtl/lava_pkg.sv
// rtl/lava_pkg.sv - shared sizes, pixel type and state encoding for the framebuffer
package lava_pkg;

    localparam int PIX_W       = 12;
    localparam int COLS        = 64;
    localparam int ROWS        = 32;
    localparam int HALF_ADDR_W = 10;

    typedef logic [PIX_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        SWAP_WAIT
    } fb_state_t;

endpackage

// File: rtl/fb_ram.sv
// rtl/fb_ram.sv - simple dual-port 1024x12 pixel RAM, sync write, registered read
module fb_ram
    import lava_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we,
    input  logic [HALF_ADDR_W-1:0] waddr,
    input  logic [PIX_W-1:0]       wdata,
    input  logic [HALF_ADDR_W-1:0] raddr,
    output logic [PIX_W-1:0]       rdata
);

    pixel_t mem [2**HALF_ADDR_W];

    // Synchronous write port; contents are never reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port; the output register clears so the panel sees black after reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/frame_buf.sv
// rtl/frame_buf.sv - double-buffered RGB444 framebuffer with hardware clear and frame-locked swap
module frame_buf
    import lava_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [5:0]             wr_x,
    input  logic [4:0]             wr_y,
    input  logic [PIX_W-1:0]       wr_data,
    input  logic                   clear_req,
    input  logic [PIX_W-1:0]       clear_color,
    input  logic                   swap_req,
    output logic                   ready,
    output logic                   swap_done,
    output logic                   front_sel,
    input  logic [HALF_ADDR_W-1:0] r_addr,
    output logic [PIX_W-1:0]       din_top,
    output logic [PIX_W-1:0]       din_btm
);

    localparam logic [HALF_ADDR_W-1:0] LAST_ADDR = HALF_ADDR_W'(COLS * ROWS / 2 - 1);

    fb_state_t              state;
    logic [HALF_ADDR_W-1:0] clr_cnt;
    pixel_t                 clr_color;
    logic [HALF_ADDR_W-1:0] prev_r_addr;
    logic                   boundary;
    logic                   back_bank;
    logic                   rd_bank;
    logic                   rd_sel;
    logic [3:0]             we;
    logic [HALF_ADDR_W-1:0] waddr;
    pixel_t                 wdata;
    pixel_t                 q [4];

    // A frame boundary is the display scan wrapping from the last address back to 0
    assign boundary  = (r_addr == '0) && (prev_r_addr == LAST_ADDR);
    assign back_bank = ~front_sel;
    // In the swap cycle itself the read already targets the incoming front bank
    assign rd_bank   = (state == SWAP_WAIT && boundary) ? ~front_sel : front_sel;

    // Track the previous display address for boundary detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_r_addr <= '0;
        end else begin
            prev_r_addr <= r_addr;
        end
    end

    // Control FSM: idle writes, full-bank clear, and waiting for a frame boundary to swap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ready     <= 1'b1;
            swap_done <= 1'b0;
            front_sel <= 1'b0;
            clr_cnt   <= '0;
            clr_color <= '0;
        end else begin
            swap_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear_req) begin
                        state     <= CLEAR;
                        ready     <= 1'b0;
                        clr_cnt   <= '0;
                        clr_color <= clear_color;
                    end else if (swap_req) begin
                        state <= SWAP_WAIT;
                        ready <= 1'b0;
                    end
                end
                CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == LAST_ADDR) begin
                        state <= IDLE;
                        ready <= 1'b1;
                    end
                end
                SWAP_WAIT: begin
                    if (boundary) begin
                        front_sel <= ~front_sel;
                        swap_done <= 1'b1;
                        state     <= IDLE;
                        ready     <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

    // Remember which bank was read so the output mux lines up with the RAM read latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_sel <= 1'b0;
        end else begin
            rd_sel <= rd_bank;
        end
    end

    // Write decode: RAM index is {bank, half}; clear hits both halves of the back bank at once
    always_comb begin
        we    = '0;
        waddr = {wr_y[3:0], wr_x};
        wdata = wr_data;
        if (state == CLEAR) begin
            we[{back_bank, 1'b0}] = 1'b1;
            we[{back_bank, 1'b1}] = 1'b1;
            waddr                 = clr_cnt;
            wdata                 = clr_color;
        end else if (state == IDLE && wr_en) begin
            we[{back_bank, wr_y[4]}] = 1'b1;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_ram
        fb_ram u_ram (
            .clk   (clk),
            .rst   (rst),
            .we    (we[i]),
            .waddr (waddr),
            .wdata (wdata),
            .raddr (r_addr),
            .rdata (q[i])
        );
    end

    assign din_top = rd_sel ? q[2] : q[0];
    assign din_btm = rd_sel ? q[3] : q[1];

endmodule
